// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the divider slice.
// Contents: datapath width, divider step-counter width and divider FSM states.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 8;
   localparam int unsigned DIV_CNT_W = $clog2(ALU_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } div_state_t;

endpackage

// File: rtl/divider_8bit_if.sv
// Start/busy handshake and result bus of the sequential divider.
// Signals: start, a, b (requester -> divider); quotient, remainder, busy,
//   done, div_zero (divider -> requester).
// Modports: master = requester (ALU decoder / bench), slave = divider.
interface divider_8bit_if #(
   parameter int unsigned WIDTH = alu_pkg::ALU_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (
      output start, a, b,
      input  quotient, remainder, busy, done, div_zero
   );

   modport slave (
      input  start, a, b,
      output quotient, remainder, busy, done, div_zero
   );

endinterface

// File: rtl/divider_8bit_div_step.sv
// One restoring-division step: shift {R,Q} left, trial-subtract D from R.
// Ports: r_i/q_i/d_i current partial remainder, quotient and divisor;
//   r_o/q_o next partial remainder and quotient; borrow_o trial went negative.
module div_step #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] r_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] r_o,
   output logic [WIDTH-1:0] q_o,
   output logic             borrow_o
);

   logic [WIDTH:0] r_shift;
   logic [WIDTH:0] trial;

   // On a borrow the shifted remainder is below D, so it fits in WIDTH bits.
   always_comb begin
      r_shift  = {r_i, q_i[WIDTH-1]};
      trial    = r_shift - {1'b0, d_i};
      borrow_o = trial[WIDTH];
      r_o      = borrow_o ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
      q_o      = {q_i[WIDTH-2:0], ~borrow_o};
   end

endmodule

// File: rtl/divider_8bit.sv
// Sequential shift/subtract divider: quotient and remainder of a / b, one
// quotient bit per clock, IDLE -> CALC -> FIX -> IDLE.
// Ports: clk, rst_n (async, active-low); bus = divider_8bit_if.slave
//   (start, a, b in; quotient, remainder, busy, done, div_zero out).
// Build option: define DIVIDER_SIGNED_EN for two's-complement operands
//   (quotient truncates toward zero, remainder takes the sign of a).
module divider_8bit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input logic           clk,
   input logic           rst_n,
   divider_8bit_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   div_state_t       state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div_zero_q, div_zero_d;
`ifdef DIVIDER_SIGNED_EN
   logic             neg_q_q, neg_q_d;
   logic             neg_r_q, neg_r_d;
`endif

   logic [WIDTH-1:0] r_step;
   logic [WIDTH-1:0] q_step;
   logic             borrow_step;

   div_step #(.WIDTH(WIDTH)) u_div_step (
      .r_i      (r_q),
      .q_i      (q_q),
      .d_i      (d_q),
      .r_o      (r_step),
      .q_o      (q_step),
      .borrow_o (borrow_step)
   );

   // Quotient bit produced by the step must be the inverse of its borrow.
   step_bit_consistent: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == CALC) |-> (q_step[0] == ~borrow_step));

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      q_d         = q_q;
      d_d         = d_q;
      count_d     = count_q;
      dz_d        = dz_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      div_zero_d  = div_zero_q;
`ifdef DIVIDER_SIGNED_EN
      neg_q_d     = neg_q_q;
      neg_r_d     = neg_r_q;
`endif

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               // Q holds the dividend magnitude; R starts at zero.
               r_d     = '0;
               count_d = '0;
               busy_d  = 1'b1;
               dz_d    = (bus.b == '0);
`ifdef DIVIDER_SIGNED_EN
               q_d     = bus.a[WIDTH-1] ? WIDTH'(WIDTH'(0) - bus.a) : bus.a;
               d_d     = bus.b[WIDTH-1] ? WIDTH'(WIDTH'(0) - bus.b) : bus.b;
               neg_q_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
               neg_r_d = bus.a[WIDTH-1];
`else
               q_d     = bus.a;
               d_d     = bus.b;
`endif
               state_d = (bus.b == '0) ? FIX : CALC;
            end
         end

         CALC: begin
            r_d     = r_step;
            q_d     = q_step;
            count_d = CNT_W'(count_q + 1'b1);
            if (count_q == CNT_W'(WIDTH - 1)) begin
               state_d = FIX;
            end
         end

         FIX: begin
            // For b==0 the untouched |a| is still in Q; restoring its sign gives a.
            if (dz_q) begin
               quotient_d  = '1;
               div_zero_d  = 1'b1;
`ifdef DIVIDER_SIGNED_EN
               remainder_d = neg_r_q ? WIDTH'(WIDTH'(0) - q_q) : q_q;
`else
               remainder_d = q_q;
`endif
            end else begin
               div_zero_d  = 1'b0;
`ifdef DIVIDER_SIGNED_EN
               quotient_d  = neg_q_q ? WIDTH'(WIDTH'(0) - q_q) : q_q;
               remainder_d = neg_r_q ? WIDTH'(WIDTH'(0) - r_q) : r_q;
`else
               quotient_d  = q_q;
               remainder_d = r_q;
`endif
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         r_q         <= '0;
         q_q         <= '0;
         d_q         <= '0;
         count_q     <= '0;
         dz_q        <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         div_zero_q  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         neg_q_q     <= 1'b0;
         neg_r_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         q_q         <= q_d;
         d_q         <= d_d;
         count_q     <= count_d;
         dz_q        <= dz_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         div_zero_q  <= div_zero_d;
`ifdef DIVIDER_SIGNED_EN
         neg_q_q     <= neg_q_d;
         neg_r_q     <= neg_r_d;
`endif
      end
   end

   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_divider_8bit.sv
// Self-checking bench for divider_8bit: expected results are queued when a
// request is issued and compared when done pulses. Follows DIVIDER_SIGNED_EN.
module tb_divider_8bit;
   import alu_pkg::*;

   localparam int unsigned W = 8;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   divider_8bit_if #(.WIDTH(W)) bus_if ();

   divider_8bit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   exp_t sb[$];
   int   total    = 0;
   int   bad      = 0;
   int   done_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, obs, expv);
      end
   endtask

   // Reference: plain integer division, independent of the shift/subtract datapath.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      if (b == '0) begin
         e.q  = '1;
         e.r  = a;
         e.dz = 1'b1;
      end else begin
`ifdef DIVIDER_SIGNED_EN
         int sa, sb_v, qq, rr;
         sa   = $signed(a);
         sb_v = $signed(b);
         qq   = sa / sb_v;
         rr   = sa % sb_v;
         e.q  = W'(qq);
         e.r  = W'(rr);
`else
         e.q  = a / b;
         e.r  = a % b;
`endif
         e.dz = 1'b0;
      end
      return e;
   endfunction

   // Result monitor: pop and compare on every done pulse.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && bus_if.done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("quotient", 32'(bus_if.quotient), 32'(e.q));
               chk("remainder", 32'(bus_if.remainder), 32'(e.r));
               chk("div_zero", 32'(bus_if.div_zero), 32'(e.dz));
               chk("busy_at_done", 32'(bus_if.busy), 32'd0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1);
   end

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      n = 0;
      while (bus_if.busy === 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 40) chk("idle_timeout", 32'd1, 32'd0);
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.a     = a;
      bus_if.b     = b;
      sb.push_back(model(a, b));
      @(posedge clk);
      #1;
      bus_if.start = 1'b0;
      chk("busy_after_accept", 32'(bus_if.busy), 32'd1);
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (bus_if.done !== 1'b1 && n < 30);
      chk(tag, 32'(n), 32'(exp_lat));
   endtask

   task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
      start_op(a, b);
      wait_done("latency", (b == '0) ? 1 : W + 1);
   endtask

   initial begin
      int d0;
      bus_if.start = 1'b0;
      bus_if.a     = '0;
      bus_if.b     = '0;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_quotient", 32'(bus_if.quotient), 32'd0);
      chk("rst_remainder", 32'(bus_if.remainder), 32'd0);
      chk("rst_busy", 32'(bus_if.busy), 32'd0);
      chk("rst_done", 32'(bus_if.done), 32'd0);
      chk("rst_div_zero", 32'(bus_if.div_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases; back-to-back since each starts in the prior done cycle
      run(8'd100, 8'd7);
      run(8'd55, 8'd0);
      run(8'd10, 8'd3);
      run(8'h9C, 8'h07);
      run(8'd100, 8'hF9);
      run(8'h80, 8'hFF);
      run(8'hFF, 8'h01);
      run(8'h80, 8'h00);
      run(8'h00, 8'h05);
      run(8'h7F, 8'h80);

      // Random operands with occasional zero divisor
      for (int i = 0; i < 24; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
         run(ra, rb);
      end

      // Start while busy is ignored: one done, first operands only
      d0 = done_cnt;
      start_op(8'd200, 8'd3);
      repeat (3) @(posedge clk);
      @(negedge clk);
      bus_if.start = 1'b1;
      bus_if.a     = 8'd9;
      bus_if.b     = 8'd9;
      @(posedge clk);
      #1;
      bus_if.start = 1'b0;
      wait_done("busy_latency", 5);
      repeat (12) @(posedge clk);
      #1;
      chk("single_done", 32'(done_cnt - d0), 32'd1);
      chk("idle_after_busy_test", 32'(bus_if.busy), 32'd0);

      // Reset mid-operation aborts with no done pulse
      start_op(8'd200, 8'd3);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(bus_if.busy), 32'd0);
      chk("abort_done", 32'(bus_if.done), 32'd0);
      chk("abort_quotient", 32'(bus_if.quotient), 32'd0);
      chk("abort_remainder", 32'(bus_if.remainder), 32'd0);
      chk("abort_div_zero", 32'(bus_if.div_zero), 32'd0);
      void'(sb.pop_back());
      d0 = done_cnt;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
      run(8'd9, 8'd4);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
